inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage directly upstream of the execute core. Each cycle it can issue one word address to a synchronous instruction memory. It captures the returned 32-bit words into a 2-entry buffer and presents them, with their PC, to execute over a valid/ready handshake. It also supports PC redirect (flush) and halt.

Parameters:
ADDR_W, 8, PC / instruction-memory word-address width
DATA_W, 32, instruction width, equal to the execute-stage IR width
RESET_PC, 0, first address fetched after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_en  out  1  read request this cycle
imem_addr  out  ADDR_W  word address of the request
imem_rdata  in  DATA_W  read data, valid the cycle after imem_en (fixed 1-cycle latency)
ir_out  out  DATA_W  instruction presented to execute
pc_out  out  ADDR_W  address of ir_out
ir_valid  out  1  ir_out/pc_out valid
ir_ready  in  1  execute accepts; transfer when ir_valid && ir_ready
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
halt  in  1  level; stop issuing new fetches
halted  out  1  fetch idle: no request outstanding, none issuing

Behaviour:
- Reset (async assert): pc=RESET_PC, imem_en=0, imem_addr=0, ir_valid=0, ir_out=0, pc_out=0, halted=0, buffer empty, outstanding=0, state=RUN.
- Reset release: first imem_en (addr RESET_PC) in the first clk after release. Data returns in the next cycle and is written to the buffer at the end of that cycle. ir_valid rises 2 cycles after issue.
- Issue rule, RUN state: imem_en=1 when occupancy + outstanding - pop < 2, where pop = ir_valid && ir_ready this cycle. On issue, pc <= pc+1, wrapping from 2^ADDR_W-1 to 0. outstanding is at most 1.
- Throughput: with ir_ready held high, one instruction is transferred per cycle.
- Buffer: 2-entry FIFO of {instr, pc}. ir_out, pc_out and ir_valid come from the head entry (registered). Push and pop in the same cycle are allowed. The buffer never overflows, by the credit rule. With ir_ready low, contents hold stable and ir_valid stays high (no drop, no change).
- Redirect, cycle N: buffer cleared at the end of N. Any response arriving in N or N+1 from a pre-redirect request is discarded (squash flag set for one response). pc <= redirect_pc. A handshake completing in cycle N still counts as transferred.
  - imem_en with redirect_pc in N+1; ir_valid with that instruction in N+3.
  - Redirect takes priority over halt for the PC update only.
- FSM states:
  - RUN: issue per rule. halt=1 -> DRAIN if outstanding=1, else HALTED.
  - DRAIN: no issue; wait for the response, which is pushed to the buffer. outstanding=0 -> HALTED. halt=0 -> RUN.
  - HALTED: halted=1, imem_en=0. Buffered instructions are still delivered. halt=0 -> RUN, with issue of the current pc in the next cycle.
- A redirect while HALTED updates pc and clears the buffer; the state stays HALTED.
- Reset mid-operation: everything returns to reset values immediately. A response arriving after reset release from a pre-reset request is ignored, because outstanding=0.

Decomposition:
- Package vpu_pkg:
  - DATA_W, ADDR_W defaults
  - IR field bit positions (oper_type, rdst, rsrc1, imm_mode, rsrc2, isrc), shared with execute
  - fetch FSM state enum {RUN, DRAIN, HALTED}
- Sub-module fetch_buf: 2-entry {instr,pc} FIFO with push/pop/flush, full/empty/count outputs.
- Top-level inst_fetch holds pc, outstanding/squash tracking, the FSM and the credit logic.

Test Plan:
- Reset, imem[i]=0x1000_0000+i, ir_ready=1 -> imem_en in cycle 1 after release; ir_valid from cycle 3; pc_out 0,1,2,3... one per cycle; ir_out = 0x1000_0000+pc_out.
- ir_ready=0 for 5 cycles after the 2nd transfer -> ir_out/pc_out held at pc 2; at most 2 requests issued beyond pc 1; resume with pc 2,3,4 with no gap or loss.
- redirect_valid with redirect_pc=0x40 while a request is in flight -> no instruction with pc between the old pc and 0x40 appears after redirect; next ir_valid at N+3 with pc_out=0x40.
- pc=0xFE, free run -> pc_out sequence 0xFE, 0xFF, 0x00, 0x01.
- halt=1 mid-stream -> imem_en drops the same cycle; halted=1 after the in-flight response; buffered instructions drained with ready=1; halt=0 -> fetch resumes at the next sequential pc.
- Assert rst with 2 entries buffered and 1 outstanding -> ir_valid=0 immediately; after release the first delivered pc_out=RESET_PC.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU definitions: default widths, instruction-register field layout
// and the fetch-stage FSM encoding.
package vpu_pkg;

  localparam int VPU_DATA_W = 32;
  localparam int VPU_ADDR_W = 8;

  // IR field positions, shared with execute; isrc overlays rsrc2 when imm_mode=1
  localparam int OPER_TYPE_MSB = 31;
  localparam int OPER_TYPE_LSB = 28;
  localparam int RDST_MSB      = 27;
  localparam int RDST_LSB      = 24;
  localparam int RSRC1_MSB     = 23;
  localparam int RSRC1_LSB     = 20;
  localparam int IMM_MODE_BIT  = 19;
  localparam int RSRC2_MSB     = 18;
  localparam int RSRC2_LSB     = 15;
  localparam int ISRC_MSB      = 18;
  localparam int ISRC_LSB      = 0;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_DRAIN,
    FS_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {instr, pc} FIFO. The head entry lives in dedicated registers so
// the execute-facing outputs come straight from flops.
module fetch_buf
  import vpu_pkg::*;
#(
  parameter int ADDR_W = VPU_ADDR_W,
  parameter int DATA_W = VPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head_instr,
  output logic [ADDR_W-1:0] head_pc,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] tail_instr;
  logic [ADDR_W-1:0] tail_pc;

  // NOTE: the storage is reset too, because head_* drive ir_out/pc_out and
  // those must read as zero out of reset; only two entries, so it is cheap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, queue shifts by one
          if (count == 2'd1) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word reads to a 1-cycle synchronous imem,
// buffers the returned words and hands them to execute over valid/ready.
module inst_fetch
  import vpu_pkg::*;
#(
  parameter int                ADDR_W   = VPU_ADDR_W,
  parameter int                DATA_W   = VPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              live;
  logic              outstanding;
  logic              squash;
  logic              pop;
  logic              push;
  logic              buf_empty;
  logic              buf_full_unused;
  logic [1:0]        buf_count;
  logic [2:0]        credit_sum;

  assign pop  = ir_valid && ir_ready;
  assign push = outstanding && !squash;

  // NOTE: issue is decided combinationally from this cycle's pop; a registered
  // decision could not keep one-per-cycle throughput without overflowing the
  // two-entry buffer when ready drops.
  always_comb begin
    credit_sum = {1'b0, buf_count} + {2'b00, outstanding} - {2'b00, pop};
    imem_en    = live && (state == FS_RUN) && !halt && (credit_sum < 3'd2);
    imem_addr  = imem_en ? pc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FS_RUN;
      pc          <= RESET_PC;
      resp_pc     <= '0;
      live        <= 1'b0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= imem_en;
      // A request issued in the redirect cycle returns next cycle and is dropped
      squash      <= redirect_valid && imem_en;
      if (imem_en) resp_pc <= pc;

      if (redirect_valid) pc <= redirect_pc;
      else if (imem_en)   pc <= pc + ADDR_W'(1);

      unique case (state)
        FS_RUN:    if (halt) state <= outstanding ? FS_DRAIN : FS_HALTED;
        FS_DRAIN: begin
          if (!halt)             state <= FS_RUN;
          else if (!outstanding) state <= FS_HALTED;
        end
        FS_HALTED: if (!halt) state <= FS_RUN;
        default:   state <= FS_RUN;
      endcase
    end
  end

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (resp_pc),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_instr (ir_out),
    .head_pc    (pc_out),
    .full       (buf_full_unused),
    .empty      (buf_empty),
    .count      (buf_count)
  );

  assign ir_valid = !buf_empty;
  assign halted   = (state == FS_HALTED);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the reference is the expected program-order
// stream {pc, imem[pc]} restarted at every reset/redirect target.
module tb_inst_fetch;

  localparam int         ADDR_W   = 8;
  localparam int         DATA_W   = 32;
  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int         WINDOW   = 512;

  logic              clk;
  logic              rst;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] pc_out;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              halted;

  inst_fetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ir_out         (ir_out),
    .pc_out         (pc_out),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory, imem[i] = 0x1000_0000 + i
  logic [DATA_W-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    imem_rdata = '0;
  end
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_xfer = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic cond);
    check(name, {31'b0, cond}, 32'd1);
  endtask

  // Expected delivery order from a restart point: consecutive pcs, wrapping
  task automatic refill(input logic [7:0] start);
    exp_q.delete();
    for (int i = 0; i < WINDOW; i++) begin
      exp_t e;
      e.pc    = start + 8'(i);
      e.instr = 32'h1000_0000 + 32'(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every valid head must equal the next expected entry; pop on transfer
  always @(negedge clk) begin
    if (rst) begin
      refill(RESET_PC);
    end else begin
      if (halted) check("halted_no_issue", {31'b0, imem_en}, 32'd0);
      if (ir_valid) begin
        checkb("sb_nonempty", exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          check("pc_out", 32'(pc_out), 32'(exp_q[0].pc));
          check("ir_out", ir_out, exp_q[0].instr);
          if (ir_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
      if (redirect_valid) refill(redirect_pc);
    end
  end

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  // Called inside cycle 0 (after release, past its falling edge)
  task automatic check_startup(input string tag);
    @(negedge clk);
    check({tag, "_c1_imem_en"}, {31'b0, imem_en}, 32'd1);
    check({tag, "_c1_imem_addr"}, 32'(imem_addr), 32'(RESET_PC));
    check({tag, "_c1_ir_valid"}, {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_c2_ir_valid"}, {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_c3_ir_valid"}, {31'b0, ir_valid}, 32'd1);
    check({tag, "_c3_pc_out"}, 32'(pc_out), 32'(RESET_PC));
  endtask

  // One-cycle redirect in cycle N; checks N+1..N+3
  task automatic do_redirect(input logic [7:0] target);
    drive_point();
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    drive_point();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_n1_imem_en", {31'b0, imem_en}, 32'd1);
    check("redir_n1_imem_addr", 32'(imem_addr), 32'(target));
    check("redir_n1_ir_valid", {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    check("redir_n2_ir_valid", {31'b0, ir_valid}, 32'd0);
    @(negedge clk);
    check("redir_n3_ir_valid", {31'b0, ir_valid}, 32'd1);
    check("redir_n3_pc_out", 32'(pc_out), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   beyond;
    int   xfer_before;
    logic got;

    rst            = 1'b0;
    ir_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_imem_en", {31'b0, imem_en}, 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_ir_out", ir_out, 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("c0_imem_en", {31'b0, imem_en}, 32'd0);
    check_startup("start");

    // Stall for 5 cycles after the second transfer
    beyond = (imem_en && imem_addr >= 8'd2) ? 1 : 0;
    @(negedge clk);
    check("xfer2_pc_out", 32'(pc_out), 32'd1);
    if (imem_en && imem_addr >= 8'd2) beyond++;
    drive_point();
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_en && imem_addr >= 8'd2) beyond++;
      check("stall_ir_valid", {31'b0, ir_valid}, 32'd1);
      check("stall_pc_out", 32'(pc_out), 32'd2);
    end
    checkb("stall_issue_bound", beyond <= 2);
    drive_point();
    ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("resume_ir_valid", {31'b0, ir_valid}, 32'd1);
      check("resume_pc_out", 32'(pc_out), 32'(2 + k));
    end

    do_redirect(8'h40);

    do_redirect(8'hFE);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("wrap_ir_valid", {31'b0, ir_valid}, 32'd1);
      check("wrap_pc_out", 32'(pc_out), 32'(8'(8'hFE + 8'(k))));
    end

    // Halt mid-stream
    drive_point();
    halt = 1'b1;
    @(negedge clk);
    check("halt_imem_en_drop", {31'b0, imem_en}, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (halted) got = 1'b1;
    end
    checkb("halt_reached", got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (!ir_valid) got = 1'b1;
      else @(negedge clk);
    end
    checkb("halt_drained", got);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkb("halt_idle", !imem_en && halted);
    end
    drive_point();
    halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("unhalt_imem_en", {31'b0, imem_en}, 32'd1);
    check("unhalt_imem_addr", 32'(imem_addr), 32'(exp_q[0].pc));

    // Reset with instructions buffered and a request in flight
    drive_point();
    ir_ready = 1'b0;
    repeat (3) @(negedge clk);
    drive_point();
    ir_ready = 1'b1;
    @(negedge clk);
    drive_point();
    rst = 1'b1;
    #1;
    check("midrst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("midrst_imem_en", {31'b0, imem_en}, 32'd0);
    check("midrst_pc_out", 32'(pc_out), 32'd0);
    check("midrst_ir_out", ir_out, 32'd0);
    check("midrst_halted", {31'b0, halted}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    check_startup("midrst");

    // Randomized traffic: ready, redirects and halt toggles
    for (int c = 0; c < 2000; c++) begin
      drive_point();
      ir_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = 8'($urandom);
      if ($urandom_range(0, 39) == 0) halt = !halt;
    end
    drive_point();
    ir_ready       = 1'b1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    xfer_before    = n_xfer;
    repeat (12) @(negedge clk);
    checkb("final_progress", (n_xfer - xfer_before) >= 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
